// File: rtl/pos_embed_token_streamer.sv
// Captures the 15x16 patch-embedding matrix, prepends the class token and streams
// 16 position-embedded, saturated token rows out over a valid/ready handshake.
module pos_embed_token_streamer #(
  parameter int NUM_PATCH = 15,
  parameter int EMB_DIM   = 16,
  parameter int DW        = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DW*NUM_PATCH*EMB_DIM-1:0]     in_mat,
  input  logic [DW*EMB_DIM-1:0]               cls_token,
  input  logic [DW*(NUM_PATCH+1)*EMB_DIM-1:0] pos_emb,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DW*EMB_DIM-1:0]               out_row,
  output logic [3:0]                          out_idx,
  output logic                                out_last,
  output logic                                busy,
  output logic [0:0]                          dbg_state
);

  // Flat layout everywhere: element [i][j] lives at bits ((i*EMB_DIM + j)*DW) +: DW.
  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; out_valid never depends on out_ready, and out_row/out_idx/out_last are
  // held while out_valid && !out_ready. in_ready is high exactly in IDLE.
  localparam int ROW_W = DW * EMB_DIM;
  localparam int MAT_W = ROW_W * NUM_PATCH;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]       state;
  logic [MAT_W-1:0] cap_buf;
  logic [ROW_W-1:0] add_a;
  logic [ROW_W-1:0] add_p;
  logic [ROW_W-1:0] next_row;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      sat_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_add = s[DW-1:0];
  endfunction

  // Operands for the row loaded on the next edge: class token in IDLE,
  // captured patch row out_idx (with positional row out_idx+1) in STREAM.
  always_comb begin
    add_a = cls_token;
    add_p = pos_emb[ROW_W-1:0];
    if (state == STREAM) begin
      add_a = '0;
      add_p = '0;
      for (int r = 0; r < NUM_PATCH; r++) begin
        if (out_idx == 4'(r)) begin
          add_a = cap_buf[r*ROW_W +: ROW_W];
          add_p = pos_emb[(r+1)*ROW_W +: ROW_W];
        end
      end
    end
    for (int j = 0; j < EMB_DIM; j++)
      next_row[j*DW +: DW] = sat_add(add_a[j*DW +: DW], add_p[j*DW +: DW]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cap_buf   <= '0;
      out_row   <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_buf   <= in_mat;
            out_row   <= next_row;
            out_idx   <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_idx == 4'(NUM_PATCH)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
            end else begin
              out_row  <= next_row;
              out_idx  <= out_idx + 4'd1;
              out_last <= (out_idx == 4'(NUM_PATCH-1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == STREAM);
  assign dbg_state = state;

endmodule

// File: tb/tb_pos_embed_token_streamer.sv
// Self-checking bench for pos_embed_token_streamer: table of uniform frames,
// randomized frames against an integer reference model, and hand-written corner cases.
module tb_pos_embed_token_streamer;

  localparam int NP    = 15;
  localparam int ED    = 16;
  localparam int DW    = 8;
  localparam int ROW_W = DW * ED;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [DW*NP*ED-1:0]     in_mat;
  logic [ROW_W-1:0]        cls_token;
  logic [DW*(NP+1)*ED-1:0] pos_emb;
  logic                    out_valid;
  logic                    out_ready;
  logic [ROW_W-1:0]        out_row;
  logic [3:0]              out_idx;
  logic                    out_last;
  logic                    busy;
  logic [0:0]              dbg_state;

  pos_embed_token_streamer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mat(in_mat),
    .cls_token(cls_token), .pos_emb(pos_emb), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- stimulus state & model ----------------
  int mat_i [NP][ED];
  int cls_i [ED];
  int pos_i [NP+1][ED];

  logic [ROW_W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  typedef struct {
    int mat_v;
    int cls_v;
    int pos0_v;
    int posr_v;
    int exp_tok0;
    int exp_tokr;
  } vec_t;

  task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rand_s8();
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    return int'($signed(r));
  endfunction

  function automatic logic [ROW_W-1:0] const_row(input int v);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < ED; j++) r[j*DW +: DW] = 8'(v);
    return r;
  endfunction

  // Token k = clip(source + pos[k]) where the source is cls for k=0, else patch k-1.
  function automatic logic [ROW_W-1:0] model_row(input int k);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < ED; j++) begin
      int s;
      s = ((k == 0) ? cls_i[j] : mat_i[k-1][j]) + pos_i[k][j];
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      r[j*DW +: DW] = 8'(s);
    end
    return r;
  endfunction

  task automatic load_model_queue();
    exp_q.delete();
    for (int k = 0; k <= NP; k++) exp_q.push_back(model_row(k));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pack_inputs();
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < ED; j++) in_mat[(i*ED+j)*DW +: DW] = 8'(mat_i[i][j]);
    for (int j = 0; j < ED; j++) cls_token[j*DW +: DW] = 8'(cls_i[j]);
    for (int i = 0; i <= NP; i++)
      for (int j = 0; j < ED; j++) pos_emb[(i*ED+j)*DW +: DW] = 8'(pos_i[i][j]);
  endtask

  task automatic fill_uniform(input int m, input int c, input int p0, input int pr);
    for (int i = 0; i < NP; i++) for (int j = 0; j < ED; j++) mat_i[i][j] = m;
    for (int j = 0; j < ED; j++) cls_i[j] = c;
    for (int j = 0; j < ED; j++) pos_i[0][j] = p0;
    for (int i = 1; i <= NP; i++) for (int j = 0; j < ED; j++) pos_i[i][j] = pr;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NP; i++) for (int j = 0; j < ED; j++) mat_i[i][j] = rand_s8();
    for (int j = 0; j < ED; j++) cls_i[j] = rand_s8();
    for (int i = 0; i <= NP; i++) for (int j = 0; j < ED; j++) pos_i[i][j] = rand_s8();
  endtask

  // Called at a negedge in IDLE; returns at the negedge right after the capture edge.
  task automatic start_frame(input bit hold_valid);
    pack_inputs();
    check("in_ready_before_capture", ROW_W'(in_ready), ROW_W'(1));
    in_valid = 1'b1;
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random ready.
  task automatic stream_frame(input int mode);
    int got = 0;
    int cyc = 0;
    bit rdy;
    while (got <= NP && cyc < 300) begin
      check("out_valid", ROW_W'(out_valid), ROW_W'(1));
      check("out_idx", ROW_W'(out_idx), ROW_W'(got));
      check("out_last", ROW_W'(out_last), ROW_W'(got == NP));
      check("busy", ROW_W'(busy), ROW_W'(1));
      check("in_ready_busy", ROW_W'(in_ready), ROW_W'(0));
      if (exp_q.size() > 0) check($sformatf("out_row_tok%0d", got), out_row, exp_q[0]);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      out_ready = rdy;
      @(negedge clk);
      if (rdy) begin
        got++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      cyc++;
    end
    out_ready = 1'b0;
    check("frame_complete", ROW_W'(got), ROW_W'(NP + 1));
    check("out_valid_after_last", ROW_W'(out_valid), ROW_W'(0));
    check("out_last_after_last", ROW_W'(out_last), ROW_W'(0));
    check("out_idx_after_last", ROW_W'(out_idx), ROW_W'(0));
    check("in_ready_after_last", ROW_W'(in_ready), ROW_W'(1));
    check("busy_after_last", ROW_W'(busy), ROW_W'(0));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [5];

  initial begin
    vecs[0] = '{mat_v:  100, cls_v:    5, pos0_v:  1, posr_v:  100, exp_tok0:    6, exp_tokr:  127};
    vecs[1] = '{mat_v: -100, cls_v:  127, pos0_v:  1, posr_v: -100, exp_tok0:  127, exp_tokr: -128};
    vecs[2] = '{mat_v: -100, cls_v: -128, pos0_v: -1, posr_v:  -28, exp_tok0: -128, exp_tokr: -128};
    vecs[3] = '{mat_v:   50, cls_v:   -3, pos0_v:  2, posr_v:   77, exp_tok0:   -1, exp_tokr:  127};
    vecs[4] = '{mat_v:   -1, cls_v:    0, pos0_v:  0, posr_v:    0, exp_tok0:    0, exp_tokr:   -1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mat = '0; cls_token = '0; pos_emb = '0;
    #12;
    check("rst_in_ready", ROW_W'(in_ready), ROW_W'(1));
    check("rst_out_valid", ROW_W'(out_valid), ROW_W'(0));
    check("rst_out_last", ROW_W'(out_last), ROW_W'(0));
    check("rst_busy", ROW_W'(busy), ROW_W'(0));
    check("rst_out_idx", ROW_W'(out_idx), ROW_W'(0));
    check("rst_out_row", out_row, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic stream: token 0 all 6, token k element j = k+j.
    for (int i = 0; i < NP; i++) for (int j = 0; j < ED; j++) mat_i[i][j] = i + j;
    for (int j = 0; j < ED; j++) cls_i[j] = 5;
    for (int i = 0; i <= NP; i++) for (int j = 0; j < ED; j++) pos_i[i][j] = 1;
    exp_q.delete();
    exp_q.push_back(const_row(6));
    for (int k = 1; k <= NP; k++) begin
      logic [ROW_W-1:0] r;
      for (int j = 0; j < ED; j++) r[j*DW +: DW] = 8'(k + j);
      exp_q.push_back(r);
    end
    start_frame(1'b0);
    stream_frame(0);

    // Table of uniform frames, with saturation boundaries.
    for (int v = 0; v < 5; v++) begin
      fill_uniform(vecs[v].mat_v, vecs[v].cls_v, vecs[v].pos0_v, vecs[v].posr_v);
      exp_q.delete();
      exp_q.push_back(const_row(vecs[v].exp_tok0));
      for (int k = 1; k <= NP; k++) exp_q.push_back(const_row(vecs[v].exp_tokr));
      start_frame(1'b0);
      stream_frame(0);
    end

    // Backpressure with a 1,0,0,1 ready pattern.
    fill_random();
    load_model_queue();
    start_frame(1'b0);
    stream_frame(1);

    // Randomized frames with random ready.
    for (int f = 0; f < 4; f++) begin
      fill_random();
      load_model_queue();
      start_frame(1'b0);
      stream_frame(2);
    end

    // in_valid held while busy, matrix changed to 0x7F after capture.
    fill_random();
    load_model_queue();
    start_frame(1'b1);
    for (int i = 0; i < NP; i++) for (int j = 0; j < ED; j++) mat_i[i][j] = 127;
    pack_inputs();
    stream_frame(2);
    load_model_queue();
    @(negedge clk);
    in_valid = 1'b0;
    stream_frame(0);

    // Reset mid-frame while out_idx == 7.
    fill_random();
    load_model_queue();
    start_frame(1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && out_idx != 4'd7; c++) @(negedge clk);
    out_ready = 1'b0;
    check("reached_idx7", ROW_W'(out_idx), ROW_W'(7));
    check("row_at_idx7", out_row, exp_q[7]);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", ROW_W'(out_valid), ROW_W'(0));
    check("midrst_out_idx", ROW_W'(out_idx), ROW_W'(0));
    check("midrst_in_ready", ROW_W'(in_ready), ROW_W'(1));
    check("midrst_busy", ROW_W'(busy), ROW_W'(0));
    check("midrst_out_row", out_row, '0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_idle", ROW_W'(out_valid), ROW_W'(0));
    end
    out_ready = 1'b0;

    // Frame after reset still works.
    fill_random();
    load_model_queue();
    start_frame(1'b0);
    stream_frame(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pos_embed_token_streamer.md
Name: pos_embed_token_streamer

Overview:
- Sits directly downstream of linear_embedding in the ECG transformer front end.
- Captures the 15x16 signed 8-bit patch-embedding matrix when linear_embedding signals done.
- Prepends a class token and adds a per-position embedding to each token with signed saturation.
- Streams the resulting 16 tokens, one 16-element row per handshake, to the encoder input.

Parameters:
NUM_PATCH, 15, patch rows captured from linear_embedding
EMB_DIM, 16, elements per token row
DW, 8, signed element width (two's complement fixed point)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  matrix available; tied to linear_embedding done
in_ready  out  1  block can capture a matrix
in_mat  in  DW x NUM_PATCH x EMB_DIM  patch embeddings [0:14][0:15]
cls_token  in  DW x EMB_DIM  class token [0:15], static weight
pos_emb  in  DW x (NUM_PATCH+1) x EMB_DIM  positional embeddings [0:15][0:15], static weight
out_valid  out  1  out_row holds a valid token
out_ready  in  1  downstream accepts token
out_row  out  DW x EMB_DIM  token elements [0:15]
out_idx  out  4  token index 0..15, where 0 is the class token
out_last  out  1  high with token 15
busy  out  1  high while not IDLE

Behaviour:
- Reset (async, immediate):
  - State is IDLE; in_ready=1.
  - out_valid=0, out_last=0, busy=0.
  - out_idx=0 and out_row all zero.
  - Capture buffer is cleared to zero.
- States: IDLE, STREAM.
- IDLE:
  - in_ready=1, busy=0.
  - On rising edge with in_valid=1, all 240 elements of in_mat are registered into the buffer.
  - On the same edge, out_row is loaded with sat(cls_token[j] + pos_emb[0][j]); out_idx=0, out_valid=1, state goes to STREAM.
  - First token is visible the cycle after capture, i.e. 1-cycle latency.
- STREAM:
  - in_ready=0, busy=1. in_valid is ignored and the buffer is not overwritten.
  - out_valid=1 continuously.
  - While out_ready=0, out_row, out_idx and out_last are held stable.
- Token accepted (out_valid && out_ready at an edge) with out_idx=k<15:
  - out_idx becomes k+1.
  - out_row becomes sat(buf[k][j] + pos_emb[k+1][j]).
  - out_last becomes 1 when k+1==15.
  - Back-to-back acceptance yields one token per cycle; 16 tokens take 16 cycles minimum.
- Token accepted with out_idx=15:
  - Next state is IDLE; out_valid=0, out_last=0, out_idx=0.
  - in_ready=1 from the following cycle, so a new in_valid can be captured no earlier than the cycle after the last token handshake.
- Arithmetic:
  - Sign-extend both operands to DW+1 bits and add.
  - A result >127 is clipped to 127; a result <-128 is clipped to -128; otherwise the low DW bits are kept.
  - Elements are independent.
- pos_emb and cls_token are sampled at each row-load edge and must be held static by the integrator.
- in_valid held high across multiple cycles in IDLE triggers exactly one capture; it is ignored until the block returns to IDLE.
- Reset asserted mid-STREAM aborts the frame immediately to reset values; no partial tokens are emitted after reset deasserts.
- out_ready may be asserted before out_valid; no handshake occurs without out_valid.

Test Plan:
- Basic stream:
  - Stimulus: in_mat[i][j]=i+j, cls_token=all 5, pos_emb=all 1, out_ready=1, one in_valid pulse.
  - Response: out_valid rises next cycle; token 0 is all 6; token k (1..15) element j is k+j; exactly 16 consecutive valid cycles; out_last only on out_idx=15; then in_ready=1.
- Saturation:
  - Stimulus: in_mat all 100 with pos_emb rows 1..15 all 100; then in_mat all -100 with pos_emb rows all -100; cls_token=127 with pos_emb[0]=1.
  - Response: first case gives tokens 1..15 all 127; second gives all -128; token 0 is 127 in the third case; no wraparound.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeating.
  - Response: out_row and out_idx stay constant on every out_ready=0 cycle; all 16 tokens arrive in order with no duplicates or drops; busy=1 throughout.
- Ignored input while busy:
  - Stimulus: in_valid held high with in_mat changed to all 0x7F after capture.
  - Response: streamed tokens reflect the originally captured matrix; a second capture happens only in the cycle after token 15 is accepted.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously (mid-cycle) while out_idx=7.
  - Response: out_valid=0, out_idx=0, in_ready=1 immediately; after release with no in_valid, out_valid stays 0.
- End-to-end:
  - Stimulus: drive linear_embedding from fixed_point_data_1.txt, embedding_wt.txt and embedding_bs.txt, with its done connected to in_valid.
  - Response: the 16 tokens match a golden model of cls/pos-embedding addition with saturation, bit-exact.
